// File: rtl/ternary_pkg.sv
// Balanced-ternary base types and digit-level arithmetic helpers shared by the ternary datapath.
// Trits use a 2-bit code; the unused code 2'b10 is treated as zero by every helper.
package ternary_pkg;

    typedef logic [1:0] trit_t;

    localparam trit_t T_ZERO = 2'b00;
    localparam trit_t T_POS  = 2'b01;
    localparam trit_t T_NEG  = 2'b11;

    typedef struct packed {
        trit_t carry;
        trit_t digit;
    } trit_sum_t;

    // Carry-out of one digit position as a function of its carry-in.
    typedef struct packed {
        trit_t on_neg;
        trit_t on_zero;
        trit_t on_pos;
    } carry_map_t;

    function automatic logic signed [2:0] trit_to_int(input trit_t t);
        case (t)
            T_POS:   trit_to_int = 3'sb001;
            T_NEG:   trit_to_int = 3'sb111;
            default: trit_to_int = 3'sb000;
        endcase
    endfunction

    function automatic trit_sum_t trit_full_add(input trit_t a, input trit_t b, input trit_t c);
        logic signed [2:0] s;
        s = trit_to_int(a) + trit_to_int(b) + trit_to_int(c);
        case (s)
            3'sb101: trit_full_add = '{carry: T_NEG,  digit: T_ZERO};
            3'sb110: trit_full_add = '{carry: T_NEG,  digit: T_POS};
            3'sb111: trit_full_add = '{carry: T_ZERO, digit: T_NEG};
            3'sb001: trit_full_add = '{carry: T_ZERO, digit: T_POS};
            3'sb010: trit_full_add = '{carry: T_POS,  digit: T_NEG};
            3'sb011: trit_full_add = '{carry: T_POS,  digit: T_ZERO};
            default: trit_full_add = '{carry: T_ZERO, digit: T_ZERO};
        endcase
    endfunction

    function automatic carry_map_t carry_map_of(input trit_t a, input trit_t b);
        trit_sum_t n;
        trit_sum_t z;
        trit_sum_t p;
        n = trit_full_add(a, b, T_NEG);
        z = trit_full_add(a, b, T_ZERO);
        p = trit_full_add(a, b, T_POS);
        carry_map_of = '{on_neg: n.carry, on_zero: z.carry, on_pos: p.carry};
    endfunction

    function automatic trit_t carry_map_apply(input carry_map_t m, input trit_t c);
        case (c)
            T_NEG:   carry_map_apply = m.on_neg;
            T_POS:   carry_map_apply = m.on_pos;
            default: carry_map_apply = m.on_zero;
        endcase
    endfunction

    // Composition: carry passes through 'first' (lower digits) then 'second'.
    function automatic carry_map_t carry_map_then(input carry_map_t first, input carry_map_t second);
        carry_map_then.on_neg  = carry_map_apply(second, first.on_neg);
        carry_map_then.on_zero = carry_map_apply(second, first.on_zero);
        carry_map_then.on_pos  = carry_map_apply(second, first.on_pos);
    endfunction

endpackage

// File: rtl/ternary_adder_configurable.sv
// Combinational balanced-ternary adder: ripple carry (USE_CLA=0) or prefix-tree lookahead (USE_CLA=1).
// Any other USE_CLA value builds the ripple form.
module ternary_adder_configurable
    import ternary_pkg::*;
#(
    parameter int WIDTH   = 27,
    parameter int USE_CLA = 0
) (
    input  trit_t [WIDTH-1:0] a,
    input  trit_t [WIDTH-1:0] b,
    input  trit_t             cin,
    output trit_t [WIDTH-1:0] sum,
    output trit_t             cout
);

    generate
        if (USE_CLA == 1) begin : g_cla
            // Kogge-Stone prefix of per-digit carry maps, then every carry resolved from cin directly.
            always_comb begin
                carry_map_t pre [WIDTH];
                trit_sum_t  r;
                trit_t      c;
                sum  = '0;
                cout = T_ZERO;
                for (int i = 0; i < WIDTH; i++) begin
                    pre[i] = carry_map_of(a[i], b[i]);
                end
                for (int l = 0; l < $clog2(WIDTH); l++) begin
                    for (int i = WIDTH - 1; i >= (1 << l); i--) begin
                        pre[i] = carry_map_then(pre[i - (1 << l)], pre[i]);
                    end
                end
                c = cin;
                for (int i = 0; i < WIDTH; i++) begin
                    r      = trit_full_add(a[i], b[i], c);
                    sum[i] = r.digit;
                    c      = carry_map_apply(pre[i], cin);
                end
                cout = c;
            end
        end else begin : g_ripple
            // Digit-serial carry chain.
            always_comb begin
                trit_sum_t r;
                trit_t     c;
                sum  = '0;
                cout = T_ZERO;
                c    = cin;
                for (int i = 0; i < WIDTH; i++) begin
                    r      = trit_full_add(a[i], b[i], c);
                    sum[i] = r.digit;
                    c      = r.carry;
                end
                cout = c;
            end
        end
    endgenerate

endmodule

// File: rtl/ternary_rr_arbiter.sv
// Combinational round-robin grant: searches ptr, ptr+1, ... (mod N) and picks the first requester.
module ternary_rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any_grant
);

    // First-hit search in rotated order; the wider index absorbs the wrap for non-power-of-two N.
    always_comb begin
        logic [IW:0]   idx_w;
        logic [IW-1:0] idx;
        logic          hit;
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx_w      = {1'b0, ptr} + (IW + 1)'(k);
            idx_w      = (idx_w >= (IW + 1)'(N)) ? (idx_w - (IW + 1)'(N)) : idx_w;
            idx        = idx_w[IW-1:0];
            hit        = !any_grant && req[idx];
            grant[idx] = grant[idx] | hit;
            grant_idx  = hit ? idx : grant_idx;
            any_grant  = any_grant | hit;
        end
    end

endmodule

// File: rtl/ternary_adder_arbiter.sv
// Round-robin sharing of one ternary adder among NREQ clients with a registered valid/ready result.
// Define TERNARY_ARB_STATS_EN to add per-requester saturating grant counters (grant_cnt).
module ternary_adder_arbiter
    import ternary_pkg::*;
#(
    parameter  int NREQ    = 4,
    parameter  int WIDTH   = 27,
    parameter  int USE_CLA = 0,
    localparam int IDW     = $clog2(NREQ)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic  [NREQ-1:0]            req_valid,
    output logic  [NREQ-1:0]            req_ready,
    input  trit_t [NREQ-1:0][WIDTH-1:0] req_a,
    input  trit_t [NREQ-1:0][WIDTH-1:0] req_b,
    input  trit_t [NREQ-1:0]            req_cin,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic  [IDW-1:0]             rsp_id,
    output trit_t [WIDTH-1:0]           rsp_sum,
    output trit_t                       rsp_cout
`ifdef TERNARY_ARB_STATS_EN
    ,
    output logic  [NREQ-1:0][15:0]      grant_cnt
`endif
);

    logic [IDW-1:0]    ptr_r;
    logic              rsp_valid_r;
    logic [IDW-1:0]    rsp_id_r;
    trit_t [WIDTH-1:0] rsp_sum_r;
    trit_t             rsp_cout_r;

    logic [NREQ-1:0]   grant_s;
    logic [IDW-1:0]    grant_idx_s;
    logic              any_grant_s;
    logic              can_accept_s;
    logic              accept_s;
    logic [IDW-1:0]    ptr_next_s;
    trit_t [WIDTH-1:0] op_a_s;
    trit_t [WIDTH-1:0] op_b_s;
    trit_t             op_cin_s;
    trit_t [WIDTH-1:0] sum_s;
    trit_t             cout_s;

    ternary_rr_arbiter #(.N(NREQ)) u_arb (
        .req       (req_valid),
        .ptr       (ptr_r),
        .grant     (grant_s),
        .grant_idx (grant_idx_s),
        .any_grant (any_grant_s)
    );

    // A held result blocks new grants unless it is consumed on this same edge.
    assign can_accept_s = !rsp_valid_r || rsp_ready;
    assign accept_s     = can_accept_s && any_grant_s;
    assign req_ready    = can_accept_s ? grant_s : '0;
    assign ptr_next_s   = (grant_idx_s == IDW'(NREQ - 1)) ? '0 : (grant_idx_s + IDW'(1));

    // Operand mux from the granted requester.
    always_comb begin
        op_a_s   = '0;
        op_b_s   = '0;
        op_cin_s = T_ZERO;
        if (any_grant_s) begin
            op_a_s   = req_a[grant_idx_s];
            op_b_s   = req_b[grant_idx_s];
            op_cin_s = req_cin[grant_idx_s];
        end else begin
            op_cin_s = T_ZERO;
        end
    end

    ternary_adder_configurable #(.WIDTH(WIDTH), .USE_CLA(USE_CLA)) u_add (
        .a    (op_a_s),
        .b    (op_b_s),
        .cin  (op_cin_s),
        .sum  (sum_s),
        .cout (cout_s)
    );

    // Round-robin pointer moves just past each accepted requester.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= '0;
        end else if (accept_s) begin
            ptr_r <= ptr_next_s;
        end
    end

    // Result register; a drain without a new accept keeps the payload and clears only valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= '0;
            rsp_sum_r   <= '0;
            rsp_cout_r  <= T_ZERO;
        end else if (accept_s) begin
            rsp_valid_r <= 1'b1;
            rsp_id_r    <= grant_idx_s;
            rsp_sum_r   <= sum_s;
            rsp_cout_r  <= cout_s;
        end else if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
        end
    end

    assign rsp_valid = rsp_valid_r;
    assign rsp_id    = rsp_id_r;
    assign rsp_sum   = rsp_sum_r;
    assign rsp_cout  = rsp_cout_r;

`ifdef TERNARY_ARB_STATS_EN
    logic [NREQ-1:0][15:0] grant_cnt_r;

    // Per-requester accept counters, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt_r <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (accept_s && grant_s[i] && (grant_cnt_r[i] != 16'hFFFF)) begin
                    grant_cnt_r[i] <= grant_cnt_r[i] + 16'd1;
                end
            end
        end
    end

    assign grant_cnt = grant_cnt_r;
`endif

endmodule

// File: tb/tb_ternary_adder_arbiter.sv
// Directed bench for ternary_adder_arbiter (NREQ=4, WIDTH=27, ripple adder).
module tb_ternary_adder_arbiter;
    import ternary_pkg::*;

    logic                clk;
    logic                rst_n;
    logic  [3:0]         req_valid;
    logic  [3:0]         req_ready;
    trit_t [3:0][26:0]   req_a;
    trit_t [3:0][26:0]   req_b;
    trit_t [3:0]         req_cin;
    logic                rsp_valid;
    logic                rsp_ready;
    logic  [1:0]         rsp_id;
    trit_t [26:0]        rsp_sum;
    trit_t               rsp_cout;
`ifdef TERNARY_ARB_STATS_EN
    logic  [3:0][15:0]   grant_cnt;
`endif

    int tests;
    int fails;
    trit_t [26:0] zero_w;
    trit_t [26:0] exp0;
    trit_t [26:0] exp3;
    trit_t [26:0] exp_sum_tab [4];
    trit_t        exp_cout_tab [4];
    logic  [3:0]  exp_rdy;

    ternary_adder_arbiter #(.NREQ(4), .WIDTH(27), .USE_CLA(0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout)
`ifdef TERNARY_ARB_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        clk = 1'b0;
        rst_n = 1'b0;
        req_valid = 4'b0000;
        rsp_ready = 1'b1;
        req_a = '0;
        req_b = '0;
        req_cin = '0;
        zero_w = '0;
        exp0 = zero_w;
        exp0[0] = T_NEG;
        exp0[1] = T_POS;
        exp3 = zero_w;
        exp3[1] = T_NEG;
        exp_sum_tab[0] = exp0;   exp_cout_tab[0] = T_ZERO;
        exp_sum_tab[1] = zero_w; exp_cout_tab[1] = T_ZERO;
        exp_sum_tab[2] = zero_w; exp_cout_tab[2] = T_POS;
        exp_sum_tab[3] = exp3;   exp_cout_tab[3] = T_ZERO;

        #12;
        check("rst_valid", 64'(rsp_valid), 64'(1'b0));
        check("rst_id",    64'(rsp_id),    64'(2'd0));
        check("rst_sum",   64'(rsp_sum),   64'(zero_w));
        check("rst_cout",  64'(rsp_cout),  64'(T_ZERO));
        check("rst_ready", 64'(req_ready), 64'(4'b0000));
`ifdef TERNARY_ARB_STATS_EN
        check("rst_cnt",   64'(grant_cnt), 64'(0));
`endif
        rst_n = 1'b1;

        // 1 + 1 in trit 0 -> trit0 = -1, trit1 = +1
        req_a[0][0] = T_POS;
        req_b[0][0] = T_POS;
        req_valid = 4'b0001;
        #1;
        check("t1_ready", 64'(req_ready), 64'(4'b0001));
        @(posedge clk); #1;
        check("t1_valid", 64'(rsp_valid), 64'(1'b1));
        check("t1_id",    64'(rsp_id),    64'(2'd0));
        check("t1_sum",   64'(rsp_sum),   64'(exp0));
        check("t1_cout",  64'(rsp_cout),  64'(T_ZERO));
        req_valid = 4'b0000;

        // all +1 plus all +1 plus cin +1 -> every digit 0, cout +1
        for (int i = 0; i < 27; i++) begin
            req_a[2][i] = T_POS;
            req_b[2][i] = T_POS;
        end
        req_cin[2] = T_POS;
        req_valid = 4'b0100;
        #1;
        check("t2_ready", 64'(req_ready), 64'(4'b0100));
        @(posedge clk); #1;
        check("t2_valid", 64'(rsp_valid), 64'(1'b1));
        check("t2_id",    64'(rsp_id),    64'(2'd2));
        check("t2_sum",   64'(rsp_sum),   64'(zero_w));
        check("t2_cout",  64'(rsp_cout),  64'(T_POS));
        req_valid = 4'b0000;
        @(posedge clk); #1;
        check("drain_valid", 64'(rsp_valid), 64'(1'b0));
        check("drain_id",    64'(rsp_id),    64'(2'd2));
        check("drain_cout",  64'(rsp_cout),  64'(T_POS));

        // -1 + -1 + -1 in trit 0 -> trit1 = -1; pointer wraps to 0 afterwards
        req_a[3][0] = T_NEG;
        req_b[3][0] = T_NEG;
        req_cin[3] = T_NEG;
        req_valid = 4'b1000;
        #1;
        check("t3_ready", 64'(req_ready), 64'(4'b1000));
        @(posedge clk); #1;
        check("t3_id",  64'(rsp_id),  64'(2'd3));
        check("t3_sum", 64'(rsp_sum), 64'(exp3));

        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            exp_rdy = 4'b0001 << (k % 4);
            #1;
            check("rr_ready", 64'(req_ready), 64'(exp_rdy));
            @(posedge clk); #1;
            check("rr_valid", 64'(rsp_valid), 64'(1'b1));
            check("rr_id",    64'(rsp_id),    64'(k % 4));
            check("rr_sum",   64'(rsp_sum),   64'(exp_sum_tab[k % 4]));
            check("rr_cout",  64'(rsp_cout),  64'(exp_cout_tab[k % 4]));
        end

        rsp_ready = 1'b0;
        req_valid = 4'b0010;
        #1;
        check("bp_ready0", 64'(req_ready), 64'(4'b0000));
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("bp_valid", 64'(rsp_valid), 64'(1'b1));
            check("bp_id",    64'(rsp_id),    64'(2'd3));
            check("bp_sum",   64'(rsp_sum),   64'(exp3));
            check("bp_ready", 64'(req_ready), 64'(4'b0000));
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_release_ready", 64'(req_ready), 64'(4'b0010));
        @(posedge clk); #1;
        check("bp_release_id",  64'(rsp_id),  64'(2'd1));
        check("bp_release_sum", 64'(rsp_sum), 64'(zero_w));

        // Accept req2 so the pointer sits at 3, then reset with req0 and req3 pending
        req_valid = 4'b0100;
        @(posedge clk); #1;
        check("pre_rst_id", 64'(rsp_id), 64'(2'd2));
        rsp_ready = 1'b0;
        req_valid = 4'b1001;
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(rsp_valid), 64'(1'b0));
        check("mid_rst_id",    64'(rsp_id),    64'(2'd0));
        #2;
        rsp_ready = 1'b1;
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", 64'(req_ready), 64'(4'b0001));
        @(posedge clk); #1;
        check("post_rst_valid", 64'(rsp_valid), 64'(1'b1));
        check("post_rst_id",    64'(rsp_id),    64'(2'd0));
        check("post_rst_sum",   64'(rsp_sum),   64'(exp0));
        req_valid = 4'b0000;

`ifdef TERNARY_ARB_STATS_EN
        rst_n = 1'b0;
        #1;
        check("cnt_clear", 64'(grant_cnt), 64'(0));
        rst_n = 1'b1;
        req_valid = 4'b0010;
        repeat (70000) @(posedge clk);
        #1;
        req_valid = 4'b0000;
        check("cnt_sat1", 64'(grant_cnt[1]), 64'(16'hFFFF));
        check("cnt_0",    64'(grant_cnt[0]), 64'(16'h0000));
        check("cnt_2",    64'(grant_cnt[2]), 64'(16'h0000));
        check("cnt_3",    64'(grant_cnt[3]), 64'(16'h0000));
`endif

        @(posedge clk); #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
